// File: rtl/dac_share_arb.sv
// dac_share_arb
// Round-robin arbiter sharing one multi-channel threshold DAC among N_CH
// channel controllers. Requests are latched per channel (coalescing repeats),
// served one at a time onto the DAC write port, and completion is reported
// back on the per-channel ready after the DAC finishes and the comparator
// settles.
//
// Ports:
//   clk_i          - clock, all logic on the rising edge
//   arst_i         - asynchronous active-high reset
//   ch_threshold_i - per-channel threshold, channel k at [k*W +: W]
//   ch_wre_i       - per-channel write request (level-sampled)
//   ch_rdy_o       - per-channel ready (1 = nothing pending or in service)
//   dac_addr_o     - DAC channel address of the current/last write
//   dac_data_o     - DAC code of the current/last write
//   dac_wre_o      - one-cycle DAC write strobe
//   dac_rdy_i      - DAC idle (low while converting)
//   busy_o         - arbiter not idle
//   err_o          - sticky ack-timeout flag
//   err_clr_i      - clears err_o (wins over a simultaneous timeout)
module dac_share_arb #(
  parameter int N_CH          = 4,
  parameter int W             = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [N_CH*W-1:0]        ch_threshold_i,
  input  logic [N_CH-1:0]          ch_wre_i,
  output logic [N_CH-1:0]          ch_rdy_o,
  output logic [$clog2(N_CH)-1:0]  dac_addr_o,
  output logic [W-1:0]             dac_data_o,
  output logic                     dac_wre_o,
  input  logic                     dac_rdy_i,
  output logic                     busy_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);

  localparam int AW   = $clog2(N_CH);
  localparam int CMAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    SETTLE
  } state_t;

  state_t          state_reg, state_next;
  logic [N_CH-1:0] pend_reg, pend_next;
  logic [AW-1:0]   ptr_reg, ptr_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [W-1:0]    data_reg, data_next;
  logic            wre_reg, wre_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            err_reg, err_next;
  logic [N_CH-1:0] rdy_reg, rdy_next;
  logic            busy_reg, busy_next;

  logic [W-1:0]    thr [N_CH];
  logic            grant_found;
  logic [AW-1:0]   grant_idx;
  logic [AW:0]     cand;
  logic [N_CH-1:0] grant_mask;
  logic            timeout;
  logic            enter_settle;
  logic            done;
  logic            svc_next;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_thr
      assign thr[gi] = ch_threshold_i[gi*W +: W];
    end
  endgenerate

  // First pending channel at or after ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, ptr_reg} + (AW+1)'(i);
      if (cand >= (AW+1)'(N_CH)) cand = cand - (AW+1)'(N_CH);
      if (!grant_found && pend_reg[cand[AW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[AW-1:0];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    wre_next     = 1'b0;
    cnt_next     = cnt_reg;
    grant_mask   = '0;
    timeout      = 1'b0;
    enter_settle = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          grant_mask[grant_idx] = 1'b1;
          addr_next  = grant_idx;
          data_next  = thr[grant_idx];
          wre_next   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_ACK;
        cnt_next   = CW'(ACK_TIMEOUT);
      end
      WAIT_ACK: begin
        // A DAC already busy at the first sample counts as the ack.
        if (!dac_rdy_i) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg <= CW'(1)) begin
          timeout      = 1'b1;
          enter_settle = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WAIT_DONE: begin
        if (dac_rdy_i) enter_settle = 1'b1;
      end
      SETTLE: begin
        if (cnt_reg <= CW'(1)) done = 1'b1;
        else                   cnt_next = cnt_reg - CW'(1);
      end
      default: state_next = IDLE;
    endcase

    // Zero settle time completes on the very edge that would enter SETTLE.
    if (enter_settle) begin
      if (SETTLE_CYCLES == 0) begin
        done = 1'b1;
      end else begin
        state_next = SETTLE;
        cnt_next   = CW'(SETTLE_CYCLES);
      end
    end

    if (done) begin
      state_next = IDLE;
      ptr_next   = (addr_reg == AW'(N_CH - 1)) ? '0 : addr_reg + AW'(1);
    end
  end

  // A request on the granted channel in the grant cycle re-pends it.
  assign pend_next = (pend_reg & ~grant_mask) | ch_wre_i;
  assign svc_next  = (state_next != IDLE);
  assign busy_next = svc_next;
  assign err_next  = err_clr_i ? 1'b0 : (timeout ? 1'b1 : err_reg);

  always_comb begin
    rdy_next = '0;
    for (int k = 0; k < N_CH; k++) begin
      rdy_next[k] = ~(pend_next[k] | (svc_next & (addr_next == AW'(k))));
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      ptr_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      wre_reg   <= 1'b0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      rdy_reg   <= '1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      ptr_reg   <= ptr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      wre_reg   <= wre_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      rdy_reg   <= rdy_next;
      busy_reg  <= busy_next;
    end
  end

  assign ch_rdy_o   = rdy_reg;
  assign dac_addr_o = addr_reg;
  assign dac_data_o = data_reg;
  assign dac_wre_o  = wre_reg;
  assign busy_o     = busy_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_dac_share_arb.sv
// Directed bench for dac_share_arb (N_CH=4, W=16). A second instance with
// zero settle time shares the stimulus and is checked only in the last test.
module tb_dac_share_arb;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [63:0] thr = '0;
  logic [3:0]  wre = '0;
  logic        dac_rdy = 1'b1;
  logic        err_clr = 1'b0;

  logic [3:0]  rdy, rdy0;
  logic [1:0]  addr, addr0;
  logic [15:0] data, data0;
  logic        dwre, dwre0;
  logic        busy, busy0;
  logic        err, err0;

  int n_vec = 0;
  int n_bad = 0;
  logic [17:0] wr_q[$];

  always #5 clk = ~clk;

  dac_share_arb #(.N_CH(4), .W(16), .SETTLE_CYCLES(8), .ACK_TIMEOUT(64)) dut (
    .clk_i(clk), .arst_i(arst), .ch_threshold_i(thr), .ch_wre_i(wre),
    .ch_rdy_o(rdy), .dac_addr_o(addr), .dac_data_o(data), .dac_wre_o(dwre),
    .dac_rdy_i(dac_rdy), .busy_o(busy), .err_o(err), .err_clr_i(err_clr));

  dac_share_arb #(.N_CH(4), .W(16), .SETTLE_CYCLES(0), .ACK_TIMEOUT(64)) dut0 (
    .clk_i(clk), .arst_i(arst), .ch_threshold_i(thr), .ch_wre_i(wre),
    .ch_rdy_o(rdy0), .dac_addr_o(addr0), .dac_data_o(data0), .dac_wre_o(dwre0),
    .dac_rdy_i(dac_rdy), .busy_o(busy0), .err_o(err0), .err_clr_i(err_clr));

  // Strobe monitor: one line per DAC write.
  always @(negedge clk) begin
    if (dwre) begin
      wr_q.push_back({addr, data});
      $display("dac write #%0d addr=%0d data=0x%04h", wr_q.size(), addr, data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_strobe();
    int t = 0;
    while (!dwre && t < 40) begin
      cyc(1);
      t++;
    end
    chk("strobe_seen", {31'd0, dwre}, 32'd1);
  endtask

  task automatic dac_cycle(input int d);
    wait_strobe();
    cyc(1);
    dac_rdy = 1'b0;
    cyc(d);
    dac_rdy = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || rdy != 4'hF) && t < 200) begin
      cyc(1);
      t++;
    end
    chk("idle", {27'd0, busy, rdy}, {27'd0, 1'b0, 4'hF});
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [1:0] a, input logic [15:0] d);
    if (i < wr_q.size()) chk(tag, {14'd0, wr_q[i]}, {14'd0, a, d});
    else                 chk({tag, "_count"}, wr_q.size(), i + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},  {28'd0, rdy}, 32'hF);
    chk({tag, "_wre"},  {31'd0, dwre}, 32'd0);
    chk({tag, "_addr"}, {30'd0, addr}, 32'd0);
    chk({tag, "_data"}, {16'd0, data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"},  {31'd0, err}, 32'd0);
  endtask

  task automatic pulse_reset();
    arst = 1'b1;
    cyc(1);
    arst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cyc(2);
    chk_reset_outputs("reset");
    arst = 1'b0;
    cyc(1);

    // ---- single request on ch2, DAC busy 10 cycles
    thr[32 +: 16] = 16'h1234;
    wre = 4'b0100;
    cyc(1);
    wre = '0;
    chk("t1_rdy_req", {28'd0, rdy}, 32'hB);
    cyc(1);
    chk("t1_strobe", {31'd0, dwre}, 32'd1);
    chk("t1_addr", {30'd0, addr}, 32'd2);
    chk("t1_data", {16'd0, data}, 32'h1234);
    cyc(1);
    chk("t1_strobe_off", {31'd0, dwre}, 32'd0);
    dac_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t1_rdy_busy", {28'd0, rdy}, 32'hB);
    end
    dac_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("t1_rdy_settle", {28'd0, rdy}, 32'hB);
    end
    cyc(1);
    chk("t1_rdy_done", {28'd0, rdy}, 32'hF);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    chk("t1_nwrites", wr_q.size(), 32'd1);
    chk_wr("t1_wr", 0, 2'd2, 16'h1234);
    chk("t1_err", {31'd0, err}, 32'd0);

    // ---- all four at once after reset: 0,1,2,3; then 0+1 -> 0,1; then 0+1+3 -> 3,0,1
    pulse_reset();
    wr_q.delete();
    thr = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    wre = 4'hF;
    cyc(1);
    wre = '0;
    chk("t2_rdy_all_low", {28'd0, rdy}, 32'h0);
    for (int i = 0; i < 4; i++) dac_cycle(3);
    wait_idle();
    for (int i = 0; i < 4; i++) chk_wr("t2_order", i, 2'(i), 16'hA000 + 16'(i) * 16'h0111);

    thr[15:0] = 16'hB000;
    thr[31:16] = 16'hB111;
    wre = 4'b0011;
    cyc(1);
    wre = '0;
    for (int i = 0; i < 2; i++) dac_cycle(2);
    wait_idle();
    chk_wr("t2_wrap0", 4, 2'd0, 16'hB000);
    chk_wr("t2_wrap1", 5, 2'd1, 16'hB111);

    wre = 4'b1011;
    cyc(1);
    wre = '0;
    for (int i = 0; i < 3; i++) dac_cycle(2);
    wait_idle();
    chk_wr("t2_rr0", 6, 2'd3, 16'hA333);
    chk_wr("t2_rr1", 7, 2'd0, 16'hB000);
    chk_wr("t2_rr2", 8, 2'd1, 16'hB111);

    // ---- coalescing on ch1 behind a ch0 write, then re-pend during service
    wr_q.delete();
    thr[15:0] = 16'hC000;
    wre = 4'b0001;
    cyc(1);
    wre = 4'b0010;
    thr[31:16] = 16'h0010;
    wait_strobe();
    cyc(2);
    wre = '0;
    thr[31:16] = 16'h0020;
    chk("t3_rdy_pend", {28'd0, rdy}, 32'hC);
    dac_rdy = 1'b0;
    cyc(3);
    dac_rdy = 1'b1;
    wait_strobe();
    chk("t3_addr", {30'd0, addr}, 32'd1);
    chk("t3_data", {16'd0, data}, 32'h0020);
    wre = 4'b0010;
    thr[31:16] = 16'h0030;
    cyc(1);
    wre = '0;
    dac_rdy = 1'b0;
    cyc(2);
    dac_rdy = 1'b1;
    dac_cycle(2);
    wait_idle();
    chk("t3_nwrites", wr_q.size(), 32'd3);
    chk_wr("t3_wr0", 0, 2'd0, 16'hC000);
    chk_wr("t3_wr1", 1, 2'd1, 16'h0020);
    chk_wr("t3_wr2", 2, 2'd1, 16'h0030);

    // ---- ack timeout on ch3
    wr_q.delete();
    thr[63:48] = 16'h0BAD;
    wre = 4'b1000;
    cyc(1);
    wre = '0;
    wait_strobe();
    cyc(1);
    cyc(63);
    chk("t4_err_early", {31'd0, err}, 32'd0);
    cyc(1);
    chk("t4_err_set", {31'd0, err}, 32'd1);
    cyc(7);
    chk("t4_rdy_settle", {28'd0, rdy}, 32'h7);
    cyc(1);
    chk("t4_rdy_done", {28'd0, rdy}, 32'hF);
    chk("t4_busy_done", {31'd0, busy}, 32'd0);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    chk_wr("t4_wr", 0, 2'd3, 16'h0BAD);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t4_err_clr", {31'd0, err}, 32'd0);

    wre = 4'b1000;
    cyc(1);
    wre = '0;
    wait_strobe();
    cyc(1);
    cyc(63);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t4_clr_prio", {31'd0, err}, 32'd0);
    cyc(1);
    chk("t4_clr_stays", {31'd0, err}, 32'd0);
    wait_idle();

    // ---- reset during WAIT_DONE
    wre = 4'b0101;
    cyc(1);
    wre = '0;
    wait_strobe();
    cyc(1);
    dac_rdy = 1'b0;
    cyc(2);
    #3;
    arst = 1'b1;
    #1;
    chk_reset_outputs("t5_async");
    @(posedge clk);
    #1;
    arst = 1'b0;
    dac_rdy = 1'b1;
    base = wr_q.size();
    cyc(20);
    chk("t5_no_strobe", wr_q.size(), base);
    chk("t5_rdy", {28'd0, rdy}, 32'hF);
    chk("t5_busy", {31'd0, busy}, 32'd0);

    // ---- zero settle time (second instance)
    thr[31:16] = 16'h5555;
    wre = 4'b0010;
    cyc(1);
    wre = '0;
    wait_strobe();
    cyc(1);
    dac_rdy = 1'b0;
    cyc(4);
    chk("t6_rdy0_busy", {28'd0, rdy0}, 32'hD);
    dac_rdy = 1'b1;
    cyc(1);
    chk("t6_rdy0_done", {28'd0, rdy0}, 32'hF);
    chk("t6_busy0", {31'd0, busy0}, 32'd0);
    chk("t6_rdy_main", {28'd0, rdy}, 32'hD);
    chk("t6_addr0", {30'd0, addr0}, 32'd1);
    chk("t6_data0", {16'd0, data0}, 32'h5555);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
